// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared width codes, FSM states and access legality for the load/store unit
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Legal width code for the direction and naturally aligned to the access size.
  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic legal;
    logic aligned;
    if (we) legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    else    legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
    case (f3[1:0])
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal & aligned;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - data memory request/grant/response port
interface lsu_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering / byte enables and load extraction / extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_ext
);

  logic [31:0] shifted;

  // Narrow stores replicate the datum so any lane the enables select carries it.
  always_comb begin
    st_be   = 4'b1111;
    st_data = st_wdata;
    case (st_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = st_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_ext = shifted;
    case (ld_funct3)
      LSU_B:   ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      LSU_H:   ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      LSU_BU:  ld_ext = {24'd0, shifted[7:0]};
      LSU_HU:  ld_ext = {16'd0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store control FSM with memory handshake, timeout and fault reporting
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        fault,
  lsu_ctrl_if.master  mem
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  logic [CW-1:0] cnt;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic        req_ok;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_ext;

  assign req_ok = access_ok(req_we, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .st_funct3 (req_funct3),
    .st_off    (req_addr[1:0]),
    .st_wdata  (req_wdata),
    .st_be     (st_be),
    .st_data   (st_data),
    .ld_funct3 (lat_funct3),
    .ld_off    (lat_off),
    .ld_rdata  (mem.mem_rdata),
    .ld_ext    (ld_ext)
  );

  // Reset also releases the pipeline at once, even with a request still presented.
  assign stall = rst_n & (((state == ST_IDLE) & req_valid & req_ok) |
                          (state == ST_REQ) | (state == ST_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      lat_funct3    <= 3'd0;
      lat_off       <= 2'd0;
      fault         <= 1'b0;
      ld_valid      <= 1'b0;
      ld_data       <= 32'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'd0;
      mem.mem_be    <= 4'd0;
      mem.mem_wdata <= 32'd0;
    end else begin
      fault    <= 1'b0;
      ld_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_ok) begin
              lat_funct3    <= req_funct3;
              lat_off       <= req_addr[1:0];
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= req_we;
              mem.mem_addr  <= {req_addr[31:2], 2'b00};
              mem.mem_be    <= req_we ? st_be : 4'b1111;
              mem.mem_wdata <= st_data;
              cnt           <= '0;
              state         <= ST_REQ;
            end else begin
              fault <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // A store grant completes the access; a load grant still needs its response.
          if (mem.mem_gnt && mem.mem_we) begin
            mem.mem_req <= 1'b0;
            state       <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            mem.mem_req <= 1'b0;
            fault       <= 1'b1;
            state       <= ST_DONE;
          end else if (mem.mem_gnt) begin
            mem.mem_req <= 1'b0;
            cnt         <= cnt + 1'b1;
            state       <= ST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem.mem_rvalid) begin
            ld_data  <= ld_ext;
            ld_valid <= 1'b1;
            state    <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            fault <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  localparam int T = 8;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
    int          r;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] sdata;
    logic [31:0] ld;
    logic        to;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        fault;

  int checks = 0;
  int failures = 0;

  lsu_ctrl_if mem_if ();

  lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .fault      (fault),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int g, input int r, input logic legal, input logic [3:0] be,
                              input logic [31:0] sdata, input logic [31:0] ld, input logic to);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.g = g; v.r = r; v.legal = legal; v.be = be; v.sdata = sdata; v.ld = ld; v.to = to;
    return v;
  endfunction

  // Reference: expectations from the ISA width rules using plain arithmetic.
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int g, input int r);
    vec_t v;
    int size;
    int off;
    logic [31:0] sh;
    logic [31:0] b;
    int needed;
    v = mk(we, f3, addr, wdata, rdata, g, r, 0, 0, 0, 0, 0);
    size = 1 << (int'(f3) % 4);
    off = int'(addr % 4);
    if (we) v.legal = (f3 < 3);
    else    v.legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (addr % size != 0) v.legal = 0;
    if (we) begin
      if (size == 4) v.be = 4'hF;
      else v.be = 4'((size == 1 ? 1 : 3) << off);
      if (size == 1)      v.sdata = (wdata & 32'hFF) * 32'h01010101;
      else if (size == 2) v.sdata = (wdata & 32'hFFFF) * 32'h00010001;
      else                v.sdata = wdata;
    end else begin
      v.be = 4'hF;
    end
    sh = rdata >> (8 * off);
    case (f3)
      3'd0: begin b = sh % 256;   v.ld = b - ((b >= 128) ? 32'd256 : 32'd0); end
      3'd1: begin b = sh % 65536; v.ld = b - ((b >= 32768) ? 32'd65536 : 32'd0); end
      3'd4: v.ld = sh % 256;
      3'd5: v.ld = sh % 65536;
      default: v.ld = sh;
    endcase
    needed = we ? g + 1 : g + r + 2;
    v.to = (needed > T);
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int n;
    logic exp_ldv;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    #1;
    chk("stall_accept", stall, v.legal);
    if (!v.legal) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("fault_illegal", fault, 1);
      chk("mem_req_illegal", mem_if.mem_req, 0);
      @(negedge clk);
      #1;
      chk("fault_one_cycle", fault, 0);
      chk("mem_req_after_illegal", mem_if.mem_req, 0);
      return;
    end
    n = v.to ? T : (v.we ? v.g + 1 : v.g + v.r + 2);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      mem_if.mem_gnt = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      #1;
      chk("stall_busy", stall, 1);
      if (c <= v.g + 1) begin
        chk("req_mem_req", mem_if.mem_req, 1);
        chk("req_mem_addr", mem_if.mem_addr, {v.addr[31:2], 2'b00});
        chk("req_mem_we", mem_if.mem_we, v.we);
        chk("req_mem_be", mem_if.mem_be, v.be);
        if (v.we) chk("req_mem_wdata", mem_if.mem_wdata, v.sdata);
        mem_if.mem_gnt = (c == v.g + 1);
        mem_if.mem_rvalid = 1'($urandom_range(0, 1));
        mem_if.mem_rdata = $urandom;
      end else begin
        chk("wait_mem_req", mem_if.mem_req, 0);
        mem_if.mem_rvalid = (c == v.g + v.r + 2);
        mem_if.mem_rdata = mem_if.mem_rvalid ? v.rdata : $urandom;
      end
    end
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    #1;
    exp_ldv = !v.we && !v.to;
    chk("done_stall", stall, 0);
    chk("done_ld_valid", ld_valid, exp_ldv);
    chk("done_fault", fault, v.to);
    chk("done_mem_req", mem_if.mem_req, 0);
    if (exp_ldv) chk("done_ld_data", ld_data, v.ld);
    req_valid = 1'b0;
  endtask

  vec_t tbl[14];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'd0;

    tbl[0]  = mk(0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1, 4'hF, 32'h0, 32'hDEADBEEF, 0);
    tbl[1]  = mk(0, 3'd0, 32'h103, 32'h0, 32'h80FF7F01, 0, 1, 1, 4'hF, 32'h0, 32'hFFFFFF80, 0);
    tbl[2]  = mk(0, 3'd4, 32'h103, 32'h0, 32'h80FF7F01, 1, 0, 1, 4'hF, 32'h0, 32'h00000080, 0);
    tbl[3]  = mk(0, 3'd1, 32'h102, 32'h0, 32'h80FF7F01, 0, 0, 1, 4'hF, 32'h0, 32'hFFFF80FF, 0);
    tbl[4]  = mk(1, 3'd0, 32'h201, 32'hAB, 32'h0, 0, 0, 1, 4'b0010, 32'hABABABAB, 32'h0, 0);
    tbl[5]  = mk(1, 3'd1, 32'h202, 32'h1234, 32'h0, 0, 0, 1, 4'b1100, 32'h12341234, 32'h0, 0);
    tbl[6]  = mk(0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0, 0, 4'hF, 32'h0, 32'h0, 0);
    tbl[7]  = mk(1, 3'd4, 32'h204, 32'h55, 32'h0, 0, 0, 0, 4'hF, 32'h0, 32'h0, 0);
    tbl[8]  = mk(0, 3'd2, 32'h300, 32'h0, 32'h13579BDF, 3, 1, 1, 4'hF, 32'h0, 32'h13579BDF, 0);
    tbl[9]  = mk(0, 3'd2, 32'h400, 32'h0, 32'h0, 99, 0, 1, 4'hF, 32'h0, 32'h0, 1);
    tbl[10] = mk(1, 3'd2, 32'h500, 32'hCAFEF00D, 32'h0, 2, 0, 1, 4'hF, 32'hCAFEF00D, 32'h0, 0);
    tbl[11] = mk(0, 3'd5, 32'h106, 32'h0, 32'h80017FFE, 0, 2, 1, 4'hF, 32'h0, 32'h00008001, 0);
    tbl[12] = mk(1, 3'd2, 32'h600, 32'h11223344, 32'h0, 99, 0, 1, 4'hF, 32'h11223344, 32'h0, 1);
    tbl[13] = mk(0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 0, 0, 4'hF, 32'h0, 32'h0, 0);

    #1;
    chk("rst_stall", stall, 0);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_fault", fault, 0);
    chk("rst_mem_req", mem_if.mem_req, 0);
    chk("rst_mem_we", mem_if.mem_we, 0);
    chk("rst_mem_addr", mem_if.mem_addr, 0);
    chk("rst_mem_be", mem_if.mem_be, 0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_txn(tbl[i]);

    // Reset while waiting for a load response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h700;
    @(negedge clk);
    mem_if.mem_gnt = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", mem_if.mem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_ld_valid", ld_valid, 0);
    chk("midrst_ld_data", ld_data, 0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("postrst_mem_req", mem_if.mem_req, 0);
    run_txn(tbl[0]);
    run_txn(tbl[4]);

    for (int i = 0; i < 60; i++) begin
      logic we;
      logic [2:0] f3;
      int g;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (we && f3 == 3'd3) f3 = 3'd2;
      g = ($urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(0, 3));
      rv = model(we, f3, 32'h1000 + 32'($urandom_range(0, 255)), $urandom, $urandom,
                 g, int'($urandom_range(0, 3)));
      run_txn(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
